// File: rtl/bus_reg_responder.sv
// Leaf register bank on the bus: decodes addr, takes writes, answers reads after READ_LATENCY cycles.
// Define BUS_REG_RESPONDER_WR_PULSE_EN to add the per-register o_wr_pulse output.
module bus_reg_responder #(
    parameter int                   NUM_REGS     = 8,
    parameter int                   ADDR_W       = 32,
    parameter int                   DATA_W       = 32,
    parameter logic [31:0]          BASE_ADDR    = 32'h0,
    parameter int                   READ_LATENCY = 1,
    parameter logic [NUM_REGS-1:0]  RO_MASK      = '0,
    parameter logic [DATA_W-1:0]    RESET_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [ADDR_W-1:0]                  i_addr,
    input  logic                               i_wr,
    input  logic [DATA_W-1:0]                  i_wr_data,
    input  logic                               i_rd,
    output logic [DATA_W-1:0]                  o_rd_data,
    output logic                               o_rd_data_valid,
`ifdef BUS_REG_RESPONDER_WR_PULSE_EN
    output logic [NUM_REGS-1:0]                o_wr_pulse,
`endif
    output logic [NUM_REGS-1:0][DATA_W-1:0]    o_regs_out,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    i_hw_in
);
    localparam int          IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [63:0] LP_LO = 64'(BASE_ADDR);
    localparam logic [63:0] LP_HI = LP_LO + 64'(4 * NUM_REGS);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("bus_reg_responder: READ_LATENCY must be 1..4");
    end
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("bus_reg_responder: NUM_REGS must be 1..64");
    end
    if (ADDR_W < $clog2(LP_HI)) begin : g_bad_addr_w
        $error("bus_reg_responder: ADDR_W too narrow for the mapped window");
    end

    logic [63:0]                       w_addr64;
    logic [63:0]                       w_off;
    logic                              w_hit;
    logic                              w_wr_hit;
    logic                              w_rd_hit;
    logic [IDX_W-1:0]                  w_idx;
    logic [DATA_W-1:0]                 w_rd_val;
    logic [NUM_REGS-1:0][DATA_W-1:0]   w_view;
    logic                              w_unused_hw;

    assign w_addr64 = 64'(i_addr);
    assign w_off    = w_addr64 - LP_LO;
    assign w_hit    = (w_addr64 >= LP_LO) && (w_addr64 < LP_HI) && (i_addr[1:0] == 2'b00);
    assign w_idx    = IDX_W'(w_off >> 2);
    assign w_wr_hit = i_wr && w_hit;
    assign w_rd_hit = i_rd && w_hit;
    // Value seen by a read is the register contents before any same-edge write.
    assign w_rd_val = w_view[w_idx];
    // hw_in lanes behind writable registers are intentionally ignored.
    assign w_unused_hw = ^i_hw_in;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign w_view[i] = i_hw_in[i];
        end else begin : g_rw
            logic [DATA_W-1:0] r_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_reg <= RESET_VALUE;
                else if (w_wr_hit && (w_idx == IDX_W'(i)))
                    r_reg <= i_wr_data;
            end
            assign w_view[i] = r_reg;
        end
    end

    assign o_regs_out = w_view;

`ifdef BUS_REG_RESPONDER_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wr_pulse;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                r_wr_pulse[i] <= w_wr_hit && (w_idx == IDX_W'(i)) && !RO_MASK[i];
        end
    end
    assign o_wr_pulse = r_wr_pulse;
`endif

    // Stage k holds a read sampled k edges ago; data is zeroed in empty stages.
    logic [READ_LATENCY:1]              r_vld_pipe;
    logic [READ_LATENCY:1][DATA_W-1:0]  r_dat_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_dat_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_hit;
            r_dat_pipe[1] <= w_rd_hit ? w_rd_val : '0;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
        end
    end

    assign o_rd_data_valid = r_vld_pipe[READ_LATENCY];
    assign o_rd_data       = r_vld_pipe[READ_LATENCY] ? r_dat_pipe[READ_LATENCY] : '0;
endmodule

// File: tb/tb_bus_reg_responder.sv
// Directed bench for bus_reg_responder: 8 regs at 0x100, read latency 3, reg 7 read-only.
module tb_bus_reg_responder;
    localparam int          NR   = 8;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [31:0] RV   = 32'h0000_005A;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [15:0]              addr = '0;
    logic                     wr = 1'b0;
    logic                     rd = 1'b0;
    logic [31:0]              wr_data = '0;
    logic [31:0]              rd_data;
    logic                     rd_vld;
    logic [NR-1:0][31:0]      regs_out;
    logic [NR-1:0][31:0]      hw_in;
`ifdef BUS_REG_RESPONDER_WR_PULSE_EN
    logic [NR-1:0]            wr_pulse;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [NR];

    bus_reg_responder #(
        .NUM_REGS(NR), .ADDR_W(16), .DATA_W(32), .BASE_ADDR(BASE),
        .READ_LATENCY(LAT), .RO_MASK(8'h80), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_addr(addr), .i_wr(wr), .i_wr_data(wr_data), .i_rd(rd),
        .o_rd_data(rd_data), .o_rd_data_valid(rd_vld),
`ifdef BUS_REG_RESPONDER_WR_PULSE_EN
        .o_wr_pulse(wr_pulse),
`endif
        .o_regs_out(regs_out), .i_hw_in(hw_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s regs_out[%0d]", tag, i), regs_out[i], model[i]);
    endtask

    // Called one edge after the read strobe was sampled.
    task automatic watch_read(input string tag, input logic [31:0] exp, input bit hit);
        for (int n = 1; n <= LAT + 2; n++) begin
            if (n > 1) tick();
            check($sformatf("%s vld@%0d", tag, n), 32'(rd_vld), 32'(hit && n == LAT));
            check($sformatf("%s data@%0d", tag, n), rd_data, (hit && n == LAT) ? exp : 32'h0);
        end
    endtask

    task automatic wr_op(input string tag, input logic [15:0] a, input logic [31:0] d);
        bit acc;
        int idx;
        addr = a; wr_data = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        idx = (int'(a) - int'(BASE)) / 4;
        acc = (a >= 16'(BASE)) && (a < 16'(BASE + 4 * NR)) && (a[1:0] == 2'b00) && (idx != 7);
        if (acc) model[idx] = d;
        check_regs(tag);
`ifdef BUS_REG_RESPONDER_WR_PULSE_EN
        check({tag, " wr_pulse"}, 32'(wr_pulse), acc ? (32'h1 << idx) : 32'h0);
        tick();
        check({tag, " wr_pulse clr"}, 32'(wr_pulse), 32'h0);
`else
        tick();
`endif
    endtask

    task automatic rd_op(input string tag, input logic [15:0] a, input logic [31:0] exp, input bit hit);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        watch_read(tag, exp, hit);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_in[i] = 32'hBAD0_0000 | 32'(i);
            model[i] = RV;
        end
        hw_in[7] = 32'h0000_A5A5;
        model[7] = 32'h0000_A5A5;

        // 1: reset
        tick();
        check("in reset vld", 32'(rd_vld), 32'h0);
        reset_n = 1'b1;
        tick(); tick();
        check_regs("reset");
        check("reset vld", 32'(rd_vld), 32'h0);
        check("reset data", rd_data, 32'h0);

        // 2: write then read back
        wr_op("t2 wr", 16'h108, 32'hCAFE_0001);
        rd_op("t2 rd", 16'h108, 32'hCAFE_0001, 1'b1);

        // 3: four back-to-back reads
        for (int i = 0; i < 4; i++) wr_op("t3 wr", 16'(BASE + 4 * i), 32'h1000 + 32'(i));
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin rd = 1'b1; addr = 16'(BASE + 4 * (c - 1)); end
            else rd = 1'b0;
            tick();
            check($sformatf("t3 vld c%0d", c), 32'(rd_vld), 32'(c >= 3 && c <= 6));
            check($sformatf("t3 data c%0d", c), rd_data, (c >= 3 && c <= 6) ? 32'h1000 + 32'(c - 3) : 32'h0);
        end
        rd = 1'b0;

        // 4: same-cycle read and write to idx1
        wr_op("t4 wr55", 16'h104, 32'h55);
        addr = 16'h104; wr_data = 32'h1234; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        model[1] = 32'h1234;
        watch_read("t4 rd old", 32'h55, 1'b1);
        check_regs("t4");
        rd_op("t4 rd new", 16'h104, 32'h1234, 1'b1);

        // 5: read-only and unmapped accesses
        wr_op("t5 wr ro", 16'h11C, 32'hDEAD_BEEF);
        wr_op("t5 wr past", 16'h120, 32'hDEAD_0001);
        wr_op("t5 wr below", 16'h0FC, 32'hDEAD_0002);
        wr_op("t5 wr misal", 16'h10A, 32'hDEAD_0003);
        wr_op("t5 wr idx5", 16'h114, 32'h0000_0500);
        rd_op("t5 rd ro", 16'h11C, 32'h0000_A5A5, 1'b1);
        rd_op("t5 rd unmapped", 16'h120, 32'h0, 1'b0);
        rd_op("t5 rd misal", 16'h106, 32'h0, 1'b0);
        rd_op("t5 rd idx6", 16'h118, RV, 1'b1);

        // 6: reset while a read is in flight
        addr = 16'h108; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        check("t6 vld in reset", 32'(rd_vld), 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) model[i] = RV;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("t6 vld after %0d", n), 32'(rd_vld), 32'h0);
            check($sformatf("t6 data after %0d", n), rd_data, 32'h0);
            tick();
        end
        check_regs("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
